// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: request sequencer in front of a single-port synchronous RAM.
// Serialises read/write requests into one response each and provides a bulk fill mode.
module ram_access_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    input  logic                  init_start,
    input  logic [DATA_WIDTH-1:0] init_value,
    output logic                  init_busy,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [2:0] {IDLE, ISSUE, RD_WAIT, RESP, INIT} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    logic                  ram_we_q, ram_we_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  is_write_q, is_write_d;
    logic                  accept;
    logic                  addr_in_range;
    logic                  init_last;

    assign req_ready        = (state_q == IDLE) & ~init_start & ~rst;
    assign accept           = req_valid & req_ready;
    assign addr_in_range    = {1'b0, req_addr} < DEPTH_EXT;
    assign init_last        = ram_addr_q == LAST_ADDR;
    assign rsp_valid        = state_q == RESP;
    assign init_busy        = state_q == INIT;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_err          = rsp_err_q;
    assign ram_data_in      = ram_din_q;
    assign ram_address      = ram_addr_q;
    assign ram_write_enable = ram_we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            is_write_q  <= 1'b0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_we_q    <= ram_we_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            is_write_q  <= is_write_d;
        end
    end

    // init_start beats a simultaneous request; out-of-range requests skip the RAM entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (init_start) begin
                    state_d = INIT;
                end else if (accept) begin
                    state_d = addr_in_range ? ISSUE : RESP;
                end
            end
            ISSUE:   state_d = is_write_q ? RESP : RD_WAIT;
            RD_WAIT: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            INIT: begin
                if (init_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM address doubles as the fill counter; it is left parked when write_enable drops
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_we_d    = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        is_write_d  = is_write_q;
        case (state_q)
            IDLE: begin
                if (init_start) begin
                    ram_addr_d = '0;
                    ram_din_d  = init_value;
                    ram_we_d   = 1'b1;
                end else if (accept) begin
                    is_write_d = req_write;
                    if (addr_in_range) begin
                        ram_addr_d = req_addr;
                        ram_we_d   = req_write;
                        if (req_write) begin
                            ram_din_d = req_wdata;
                        end
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (is_write_q) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            RD_WAIT: begin
                rsp_rdata_d = ram_data_out;
                rsp_err_d   = 1'b0;
            end
            INIT: begin
                if (!init_last) begin
                    ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
                    ram_we_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
Request sequencer sitting directly upstream of the 32x8 single-port synchronous RAM. It accepts read/write requests over a valid/ready handshake and drives the RAM's data_in/address/write_enable pins. It captures the RAM's read data and returns one response per request over a second valid/ready handshake. It also provides a bulk-init mode that fills every RAM word with a constant.

Parameters:
DATA_WIDTH, 8, RAM word width
ADDR_WIDTH, 6, request/RAM address width
DEPTH, 32, number of implemented RAM words; addresses >= DEPTH are out of range

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid & req_ready at a rising edge
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  request address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  DATA_WIDTH  read data (0 for writes/errors)
rsp_err  output  1  1 = address out of range
init_start  input  1  pulse: begin bulk fill
init_value  input  DATA_WIDTH  fill value, sampled with init_start
init_busy  output  1  fill in progress
ram_data_in  output  DATA_WIDTH  to RAM data_in
ram_address  output  ADDR_WIDTH  to RAM address
ram_write_enable  output  1  to RAM write_enable
ram_data_out  input  DATA_WIDTH  from RAM data_out

Behaviour:
- Reset: state IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=0. ram_write_enable=0, ram_address=0, ram_data_in=0. Reset in any state (including mid-INIT or RESP) aborts the operation with no response. RAM contents after an aborted init are unspecified.
- RAM-side outputs are registered.
  - ram_write_enable is 1 only in ISSUE-for-write and INIT cycles.
  - In every other cycle ram_write_enable=0 and ram_address holds its last value. The RAM relatches the same address, so read data stays stable.
- req_ready = (state==IDLE) & ~init_start. It is 0 during rst.
- States:
  - IDLE:
    - init_start=1: latch init_value, go to INIT. init_start has priority over a simultaneous req_valid, which is not accepted.
    - Accepted request with req_addr >= DEPTH: no RAM access; load rsp_err=1, rsp_rdata=0; go to RESP.
    - Accepted in-range request: register ram_address=req_addr, ram_data_in=req_wdata (write) or unchanged (read), ram_write_enable=req_write; go to ISSUE.
  - ISSUE: RAM pins driven this cycle.
    - Write: deassert write_enable next; go to RESP with rsp_rdata=0, rsp_err=0.
    - Read: RAM registers address at this edge; go to RD_WAIT.
  - RD_WAIT: ram_data_out valid; capture into rsp_rdata, rsp_err=0; go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready, then go to IDLE with rsp_valid=0 next cycle.
  - INIT:
    - init_busy=1 and ram_write_enable=1 for exactly DEPTH consecutive cycles.
    - ram_address runs 0,1,...,DEPTH-1; ram_data_in = latched value.
    - After the write to DEPTH-1: write_enable=0, init_busy=0, return to IDLE. Address does not wrap.
    - init_start outside IDLE is ignored.
- Latency (request accepted at edge ending cycle T):
  - Out-of-range: rsp_valid in T+1.
  - Write: RAM write occurs at end of T+1; rsp_valid in T+2.
  - Read: RAM address registered at end of T+1, data captured at end of T+2; rsp_valid in T+3.
- One request outstanding at a time. Every accepted request yields exactly one response, in order. Peak throughput: one write per 3 cycles, one read per 4 cycles, with rsp_ready held 1.
- Inputs are sampled only on the accepting edge; changes to req_* afterwards have no effect.

Test Plan:
- Reset: hold rst 2 cycles with req_valid=1 -> no accept; after release req_ready=1, rsp_valid=0, ram_write_enable=0, ram_address=0.
- Write then read:
  - Write addr 5 data 0x3C -> ram_write_enable=1 with address 5 and data 0x3C in T+1; rsp_valid in T+2 with err=0.
  - Read addr 5 -> rsp_valid in T+3, rsp_rdata=0x3C.
- Out of range: read addr 40 -> rsp_valid in T+1, rsp_err=1, rsp_rdata=0, ram_write_enable never 1.
- Backpressure: read addr 5 with rsp_ready=0 for 5 cycles -> rsp_valid stays 1 with rsp_rdata=0x3C stable; req_ready=0 throughout; releases on the handshake.
- Init:
  - Pulse init_start with init_value=0xA5 -> init_busy high exactly 32 cycles, addresses 0..31 written.
  - Then read addr 0 and addr 31 -> both 0xA5.
  - init_start and req_valid asserted in the same cycle -> init wins; the request is accepted only after init_busy falls.
- Reset mid-init: assert rst at fill address 10 -> next cycle init_busy=0, ram_write_enable=0, state IDLE, req_ready=1 after release.
